// File: rtl/d7s_lector.sv
// Reader for a multiplexed, active-low 7-segment scan bus: filters the inputs,
// decodes each digit and assembles units/tens/hundreds into a binary value.
module d7s_lector #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] transistor,
  input  logic [6:0] d7sp,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [9:0] value,
  output logic       valid,
  output logic       seg_err,
  output logic       seq_err,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0] SEL_D1 = 3'b110;
  localparam logic [2:0] SEL_D2 = 3'b101;
  localparam logic [2:0] SEL_D3 = 3'b011;

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] STAB_ARM = 4'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_D1,
    WAIT_D2,
    WAIT_D3,
    CONV_A,
    CONV_B
  } state_t;

  state_t      state;
  logic [9:0]  in_q;
  logic [3:0]  stab_cnt;
  logic [3:0]  d1_r;
  logic [3:0]  d2_r;
  logic [3:0]  d3_r;
  logic [6:0]  acc;

  logic [9:0]  cur;
  logic        same;
  logic        sel_digit;
  logic        capture;
  logic [3:0]  dig;
  logic        dig_ok;
  logic [6:0]  acc_next;
  logic [9:0]  acc_w;
  logic [9:0]  value_next;

  assign cur       = {transistor, d7sp};
  assign same      = (cur == in_q);
  assign sel_digit = (transistor == SEL_D1) || (transistor == SEL_D2) ||
                     (transistor == SEL_D3);
  // Fires once per dwell: the counter passes STAB_ARM only on its way up.
  assign capture   = same && (stab_cnt == STAB_ARM) && sel_digit;

  always_comb begin
    dig    = '0;
    dig_ok = 1'b1;
    case (d7sp)
      7'b0000001: dig = 4'd0;
      7'b1001111: dig = 4'd1;
      7'b0010010: dig = 4'd2;
      7'b0000110: dig = 4'd3;
      7'b1001100: dig = 4'd4;
      7'b0100100: dig = 4'd5;
      7'b0100000: dig = 4'd6;
      7'b0001111: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0000100: dig = 4'd9;
      default:    dig_ok = 1'b0;
    endcase
  end

  // x*10 as (x<<3)+(x<<1), sized so the maxima (99, 999) never truncate.
  assign acc_next   = {d3_r, 3'b000} + {2'b00, d3_r, 1'b0} + {3'b000, d2_r};
  assign acc_w      = {3'b000, acc};
  assign value_next = (acc_w << 3) + (acc_w << 1) + {6'b000000, d1_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_D1;
      in_q      <= '0;
      stab_cnt  <= '0;
      d1_r      <= '0;
      d2_r      <= '0;
      d3_r      <= '0;
      acc       <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      value     <= '0;
      valid     <= 1'b0;
      seg_err   <= 1'b0;
      seq_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      in_q <= cur;
      if (!same)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 4'd1;

      valid   <= 1'b0;
      seg_err <= 1'b0;
      seq_err <= 1'b0;

      case (state)
        WAIT_D1, WAIT_D2, WAIT_D3: begin
          if (capture) begin
            if (!dig_ok) begin
              seg_err <= 1'b1;
              state   <= WAIT_D1;
            end else begin
              case (transistor)
                SEL_D1: begin
                  d1_r  <= dig;
                  state <= WAIT_D2;
                end
                SEL_D2: begin
                  if (state == WAIT_D2) begin
                    d2_r  <= dig;
                    state <= WAIT_D3;
                  end else begin
                    seq_err <= 1'b1;
                    state   <= WAIT_D1;
                  end
                end
                SEL_D3: begin
                  if (state == WAIT_D3) begin
                    d3_r  <= dig;
                    state <= CONV_A;
                  end else begin
                    seq_err <= 1'b1;
                    state   <= WAIT_D1;
                  end
                end
                default: state <= state;
              endcase
            end
          end
        end
        CONV_A: begin
          acc   <= acc_next;
          state <= CONV_B;
        end
        CONV_B: begin
          value     <= value_next;
          d1        <= d1_r;
          d2        <= d2_r;
          d3        <= d3_r;
          valid     <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          state     <= WAIT_D1;
        end
        default: state <= WAIT_D1;
      endcase
    end
  end

endmodule

// File: tb/tb_d7s_lector.sv
// Directed bench for d7s_lector: scans digits onto the bus and checks frames,
// flags, latency, counter wrap and mid-frame reset against hand-derived values.
module tb_d7s_lector;

  logic       clk;
  logic       rst;
  logic [2:0] transistor;
  logic [6:0] d7sp;
  logic [3:0] d1, d2, d3;
  logic [9:0] value;
  logic       valid, seg_err, seq_err;
  logic [7:0] frame_cnt;

  int unsigned n_vec;
  int unsigned n_bad;
  int unsigned v_cnt, se_cnt, qe_cnt;

  logic [6:0] seg_of [10];

  d7s_lector #(.STABLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .transistor(transistor), .d7sp(d7sp),
    .d1(d1), .d2(d2), .d3(d3), .value(value), .valid(valid),
    .seg_err(seg_err), .seq_err(seq_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [2:0] s, input logic [6:0] g);
    transistor = s;
    d7sp       = g;
    @(posedge clk);
    @(negedge clk);
    if (valid)   v_cnt++;
    if (seg_err) se_cnt++;
    if (seq_err) qe_cnt++;
  endtask

  task automatic dwell(input logic [2:0] s, input logic [6:0] g, input int n);
    for (int i = 0; i < n; i++) step(s, g);
  endtask

  task automatic idle(input int n);
    dwell(3'b111, 7'b1111111, n);
  endtask

  task automatic frame(input int u, input int t, input int h);
    dwell(3'b110, seg_of[u], 4);
    dwell(3'b101, seg_of[t], 4);
    dwell(3'b011, seg_of[h], 4);
    idle(3);
  endtask

  task automatic clr_cnt();
    v_cnt = 0; se_cnt = 0; qe_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_vec++; if ({d1, d2, d3} !== 12'h000) begin n_bad++; $display("FAIL reset_digits got %h want 000", {d1, d2, d3}); end
    n_vec++; if (value !== 10'd0) begin n_bad++; $display("FAIL reset_value got %0d want 0", value); end
    n_vec++; if ({valid, seg_err, seq_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {valid, seg_err, seq_err}); end
    n_vec++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
  endtask

  task automatic test_normal();
    clr_cnt();
    dwell(3'b110, seg_of[3], 4);
    dwell(3'b101, seg_of[2], 4);
    dwell(3'b011, seg_of[1], 3);
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL lat_capture_edge got %b want 0", valid); end
    step(3'b011, seg_of[1]);
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL lat_edge1 got %b want 0", valid); end
    idle(1);
    n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL lat_edge2 got %b want 1", valid); end
    n_vec++; if (value !== 10'd123) begin n_bad++; $display("FAIL normal_value got %0d want 123", value); end
    n_vec++; if ({d3, d2, d1} !== 12'h123) begin n_bad++; $display("FAIL normal_digits got %h want 123", {d3, d2, d1}); end
    n_vec++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL normal_frame_cnt got %0d want 1", frame_cnt); end
    idle(1);
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL valid_one_cycle got %b want 0", valid); end
    n_vec++; if (v_cnt !== 1 || se_cnt !== 0 || qe_cnt !== 0) begin n_bad++; $display("FAIL normal_pulses got v%0d s%0d q%0d want v1 s0 q0", v_cnt, se_cnt, qe_cnt); end
  endtask

  task automatic test_max_repeat();
    clr_cnt();
    frame(9, 9, 9);
    n_vec++; if (value !== 10'd999) begin n_bad++; $display("FAIL max1_value got %0d want 999", value); end
    frame(9, 9, 9);
    n_vec++; if (value !== 10'd999) begin n_bad++; $display("FAIL max2_value got %0d want 999", value); end
    n_vec++; if (frame_cnt !== 8'd3 || v_cnt !== 2) begin n_bad++; $display("FAIL max_counts got fc%0d v%0d want fc3 v2", frame_cnt, v_cnt); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; idle(1); rst = 1'b0;
    clr_cnt();
    for (int i = 0; i < 255; i++) frame(5, 5, 2);
    n_vec++; if (frame_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_pre got %0d want 255", frame_cnt); end
    frame(5, 5, 2);
    n_vec++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_cnt got %0d want 0", frame_cnt); end
    n_vec++; if (value !== 10'd255 || v_cnt !== 256) begin n_bad++; $display("FAIL wrap_value got %0d v%0d want 255 v256", value, v_cnt); end
  endtask

  task automatic test_glitch();
    clr_cnt();
    dwell(3'b110, seg_of[5], 4);
    idle(2);
    step(3'b101, 7'b0000000);
    idle(2);
    dwell(3'b101, 7'b1110000, 2);
    idle(2);
    dwell(3'b101, seg_of[4], 4);
    step(3'b101, 7'b0110110);
    dwell(3'b011, 7'b0000001, 2);
    dwell(3'b011, seg_of[6], 4);
    idle(3);
    n_vec++; if (value !== 10'd645) begin n_bad++; $display("FAIL glitch_value got %0d want 645", value); end
    n_vec++; if (v_cnt !== 1 || se_cnt !== 0 || qe_cnt !== 0) begin n_bad++; $display("FAIL glitch_pulses got v%0d s%0d q%0d want v1 s0 q0", v_cnt, se_cnt, qe_cnt); end
  endtask

  task automatic test_seg_err();
    clr_cnt();
    dwell(3'b110, seg_of[0], 4);
    dwell(3'b101, 7'b0111111, 4);
    idle(3);
    n_vec++; if (se_cnt !== 1 || v_cnt !== 0 || qe_cnt !== 0) begin n_bad++; $display("FAIL segerr_pulses got v%0d s%0d q%0d want v0 s1 q0", v_cnt, se_cnt, qe_cnt); end
    n_vec++; if (value !== 10'd645 || {d3, d2, d1} !== 12'h645) begin n_bad++; $display("FAIL segerr_hold got %0d/%h want 645", value, {d3, d2, d1}); end
    clr_cnt();
    frame(0, 0, 0);
    n_vec++; if (value !== 10'd0 || v_cnt !== 1) begin n_bad++; $display("FAIL zero_frame got %0d v%0d want 0 v1", value, v_cnt); end
  endtask

  task automatic test_seq_err();
    clr_cnt();
    dwell(3'b101, seg_of[5], 4);
    n_vec++; if (qe_cnt !== 1) begin n_bad++; $display("FAIL seqerr_first got %0d want 1", qe_cnt); end
    dwell(3'b011, seg_of[3], 4);
    idle(3);
    n_vec++; if (qe_cnt !== 2 || v_cnt !== 0 || se_cnt !== 0) begin n_bad++; $display("FAIL seqerr_pulses got v%0d s%0d q%0d want v0 s0 q2", v_cnt, se_cnt, qe_cnt); end
    clr_cnt();
    dwell(3'b110, seg_of[4], 4);
    dwell(3'b110, seg_of[7], 4);
    dwell(3'b101, seg_of[0], 4);
    dwell(3'b011, seg_of[2], 4);
    idle(3);
    n_vec++; if (value !== 10'd207 || {d3, d2, d1} !== 12'h207) begin n_bad++; $display("FAIL restart_value got %0d/%h want 207", value, {d3, d2, d1}); end
    n_vec++; if (qe_cnt !== 0 || se_cnt !== 0 || v_cnt !== 1) begin n_bad++; $display("FAIL restart_pulses got v%0d s%0d q%0d want v1 s0 q0", v_cnt, se_cnt, qe_cnt); end
  endtask

  task automatic test_reset_mid();
    dwell(3'b110, seg_of[8], 4);
    dwell(3'b101, seg_of[6], 4);
    rst = 1'b1;
    step(3'b011, seg_of[1]);
    rst = 1'b0;
    n_vec++; if (value !== 10'd0 || {d3, d2, d1} !== 12'h000 || frame_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_outputs got %0d/%h fc%0d want 0/000 fc0", value, {d3, d2, d1}, frame_cnt); end
    idle(3);
    clr_cnt();
    frame(8, 6, 1);
    n_vec++; if (value !== 10'd168 || {d3, d2, d1} !== 12'h168) begin n_bad++; $display("FAIL midrst_frame got %0d/%h want 168", value, {d3, d2, d1}); end
    n_vec++; if (frame_cnt !== 8'd1 || v_cnt !== 1) begin n_bad++; $display("FAIL midrst_cnt got fc%0d v%0d want fc1 v1", frame_cnt, v_cnt); end
  endtask

  initial begin
    seg_of[0] = 7'b0000001; seg_of[1] = 7'b1001111; seg_of[2] = 7'b0010010;
    seg_of[3] = 7'b0000110; seg_of[4] = 7'b1001100; seg_of[5] = 7'b0100100;
    seg_of[6] = 7'b0100000; seg_of[7] = 7'b0001111; seg_of[8] = 7'b0000000;
    seg_of[9] = 7'b0000100;
    n_vec = 0; n_bad = 0;
    clr_cnt();
    rst = 1'b1; transistor = 3'b111; d7sp = 7'b1111111;
    @(negedge clk);
    test_reset();
    test_normal();
    test_max_repeat();
    test_wrap();
    test_glitch();
    test_seg_err();
    test_seq_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
